cic_comp_fir: RTL and testbench

Parametrised, runtime-programmable symmetric odd-length FIR used as the CIC droop compensator after each CIC decimator in the demod chain. It uses one time-shared pre-add/multiply/accumulate datapath over the (NUM_TAPS+1)/2 unique coefficients. It provides a valid/ready input handshake and a double-buffered coefficient bank with a glitch-free swap. A group-delay-matched bypass and a sticky saturation flag are included.

---
 rtl/cic_comp_fir.sv | 209 ++++++++++++++++++++
 tb/tb_cic_comp_fir.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cic_comp_fir.sv
// cic_comp_fir: symmetric odd-length FIR used as a CIC droop compensator.
// One time-shared pre-add/multiply/accumulate over the (NUM_TAPS+1)/2 unique taps.
// Ports:
//   clk, reset_n          clock, synchronous active-low reset
//   in_valid/in_ready     input handshake, in_data sample, bypass flag
//   coef_we/addr/data     shadow coefficient write port
//   coef_swap             request shadow->active copy, swap_pending status
//   sat_clr               clears the sticky sat_flag
//   out_valid/out_data    one-cycle output pulse, data held between pulses
module cic_comp_fir #(
    parameter int DATA_W   = 18,
    parameter int COEF_W   = 18,
    parameter int NUM_TAPS = 7,
    localparam int U       = (NUM_TAPS + 1) / 2,
    localparam int AW      = $clog2(U)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              bypass,
    input  logic              coef_we,
    input  logic [AW-1:0]     coef_addr,
    input  logic [COEF_W-1:0] coef_data,
    input  logic              coef_swap,
    output logic              swap_pending,
    input  logic              sat_clr,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              sat_flag
);

    localparam int MID    = U - 1;
    localparam int TW     = $clog2(NUM_TAPS);
    localparam int PRE_W  = DATA_W + 1;
    localparam int PROD_W = PRE_W + COEF_W;
    localparam int ACC_W  = DATA_W + COEF_W + 1 + AW;

    localparam logic [AW-1:0] MID_A = AW'(MID);
    localparam logic signed [COEF_W-1:0] COEF_ONE =
        {1'b0, {(COEF_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] RND =
        {{(ACC_W-COEF_W+1){1'b0}}, 1'b1, {(COEF_W-2){1'b0}}};
    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = -SAT_MAX;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACC,
        S_OUT
    } state_t;

    state_t state_q, state_d;
    logic [AW-1:0] k_q, k_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [DATA_W-1:0] x_q [NUM_TAPS];
    logic signed [DATA_W-1:0] x_d [NUM_TAPS];
    logic signed [COEF_W-1:0] shadow_q [U];
    logic signed [COEF_W-1:0] shadow_d [U];
    logic signed [COEF_W-1:0] act_q [U];
    logic signed [COEF_W-1:0] act_d [U];
    logic byp_q, byp_d;
    logic pend_q, pend_d;
    logic rdy_q, rdy_d;
    logic out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic sat_q, sat_d;

    logic addr_ok;
    logic [TW-1:0] ia, ib;
    logic signed [DATA_W-1:0] tap_a, tap_b;
    logic signed [PRE_W-1:0] pre;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0] rnd, res;

    // Only non-power-of-two U leaves unused addresses to reject.
    if (U == (1 << AW)) begin : g_addr_full
        assign addr_ok = 1'b1;
    end else begin : g_addr_chk
        assign addr_ok = (coef_addr <= MID_A);
    end

    // Mirror tap pair; at the centre tap only x[MID] contributes.
    always_comb begin
        ia    = TW'(k_q);
        ib    = TW'(NUM_TAPS - 1) - ia;
        tap_a = x_q[ia];
        tap_b = (k_q == MID_A) ? '0 : x_q[ib];
        pre   = {tap_a[DATA_W-1], tap_a} + {tap_b[DATA_W-1], tap_b};
        prod  = pre * act_q[k_q];
        rnd   = acc_q + RND;
        res   = rnd >>> (COEF_W - 1);
    end

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        acc_d       = acc_q;
        x_d         = x_q;
        byp_d       = byp_q;
        shadow_d    = shadow_q;
        act_d       = act_q;
        pend_d      = pend_q | coef_swap;
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;
        sat_d       = sat_q;

        if (sat_clr) begin
            sat_d = 1'b0;
        end

        if (coef_we && addr_ok) begin
            shadow_d[coef_addr] = coef_data;
        end

        // Copy uses the pre-write shadow, so a same-edge write misses it.
        if (state_q == S_IDLE && pend_q) begin
            act_d  = shadow_q;
            pend_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    x_d[0] = in_data;
                    for (int i = 1; i < NUM_TAPS; i++) begin
                        x_d[i] = x_q[i-1];
                    end
                    byp_d   = bypass;
                    k_d     = '0;
                    acc_d   = '0;
                    state_d = S_ACC;
                end
            end
            S_ACC: begin
                acc_d = acc_q
                      + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
                if (k_q == MID_A) begin
                    state_d = S_OUT;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            S_OUT: begin
                out_valid_d = 1'b1;
                state_d     = S_IDLE;
                if (byp_q) begin
                    out_data_d = x_q[MID];
                end else if (res > SAT_MAX) begin
                    out_data_d = SAT_MAX[DATA_W-1:0];
                    sat_d      = 1'b1;
                end else if (res < SAT_MIN) begin
                    out_data_d = SAT_MIN[DATA_W-1:0];
                    sat_d      = 1'b1;
                end else begin
                    out_data_d = res[DATA_W-1:0];
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        rdy_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            k_q         <= '0;
            acc_q       <= '0;
            byp_q       <= 1'b0;
            pend_q      <= 1'b0;
            rdy_q       <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            sat_q       <= 1'b0;
            for (int i = 0; i < NUM_TAPS; i++) begin
                x_q[i] <= '0;
            end
            for (int i = 0; i < U; i++) begin
                shadow_q[i] <= (i == MID) ? COEF_ONE : '0;
                act_q[i]    <= (i == MID) ? COEF_ONE : '0;
            end
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            acc_q       <= acc_d;
            byp_q       <= byp_d;
            pend_q      <= pend_d;
            rdy_q       <= rdy_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            sat_q       <= sat_d;
            x_q         <= x_d;
            shadow_q    <= shadow_d;
            act_q       <= act_d;
        end
    end

    assign in_ready     = rdy_q;
    assign swap_pending = pend_q;
    assign out_valid    = out_valid_q;
    assign out_data     = out_data_q;
    assign sat_flag     = sat_q;

endmodule

// File: tb/tb_cic_comp_fir.sv
// tb_cic_comp_fir: directed bench for cic_comp_fir with a scoreboard queue.
// Expected samples are pushed at accept and popped when out_valid pulses.
module tb_cic_comp_fir;

    localparam int DW  = 18;
    localparam int CW  = 18;
    localparam int NT  = 7;
    localparam int U   = 4;
    localparam int MID = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_n;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          bypass;
    logic          coef_we;
    logic [1:0]    coef_addr;
    logic [CW-1:0] coef_data;
    logic          coef_swap;
    logic          swap_pending;
    logic          sat_clr;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          sat_flag;

    cic_comp_fir #(
        .DATA_W  (DW),
        .COEF_W  (CW),
        .NUM_TAPS(NT)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .bypass      (bypass),
        .coef_we     (coef_we),
        .coef_addr   (coef_addr),
        .coef_data   (coef_data),
        .coef_swap   (coef_swap),
        .swap_pending(swap_pending),
        .sat_clr     (sat_clr),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .sat_flag    (sat_flag)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [DW-1:0] data;
        int            cyc;
    } sb_t;

    sb_t sb[$];
    sb_t mon_e;

    logic [DW-1:0] md[NT];
    logic [CW-1:0] m_act[U];
    logic [CW-1:0] m_shadow[U];
    bit            m_pend;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic longint sx(input logic [17:0] v);
        return longint'(signed'(v));
    endfunction

    function automatic logic [DW-1:0] model(input bit byp);
        longint acc;
        longint r;
        acc = 0;
        for (int k = 0; k < MID; k++) begin
            acc += (sx(md[k]) + sx(md[NT-1-k])) * sx(m_act[k]);
        end
        acc += sx(md[MID]) * sx(m_act[MID]);
        r = (acc + 64'sd65536) >>> 17;
        if (byp) return md[MID];
        if (r > 131071) r = 131071;
        else if (r < -131071) r = -131071;
        return r[DW-1:0];
    endfunction

    task automatic reset_model();
        for (int i = 0; i < NT; i++) md[i] = '0;
        for (int i = 0; i < U; i++) begin
            m_act[i]    = (i == MID) ? 18'h1FFFF : 18'h0;
            m_shadow[i] = (i == MID) ? 18'h1FFFF : 18'h0;
        end
        m_pend = 1'b0;
    endtask

    task automatic check_reset_vals(input string ph);
        chk({ph, "_in_ready"}, in_ready, 1);
        chk({ph, "_out_valid"}, out_valid, 0);
        chk({ph, "_out_data"}, out_data, 0);
        chk({ph, "_sat_flag"}, sat_flag, 0);
        chk({ph, "_swap_pending"}, swap_pending, 0);
    endtask

    task automatic write_coefs(input logic [CW-1:0] c0,
                               input logic [CW-1:0] c1,
                               input logic [CW-1:0] c2,
                               input logic [CW-1:0] c3);
        logic [CW-1:0] c[U];
        c = '{c0, c1, c2, c3};
        for (int i = 0; i < U; i++) begin
            @(negedge clk);
            coef_we   = 1'b1;
            coef_addr = 2'(i);
            coef_data = c[i];
            m_shadow[i] = c[i];
        end
        @(negedge clk);
        coef_we = 1'b0;
    endtask

    // Idle-time swap: latched on one edge, copied on the next.
    task automatic pulse_swap_idle();
        @(negedge clk);
        coef_swap = 1'b1;
        m_pend    = 1'b1;
        @(posedge clk);
        #1;
        coef_swap = 1'b0;
        chk("swap_pending_set", swap_pending, 1);
        repeat (2) @(negedge clk);
        chk("swap_pending_idle_clear", swap_pending, 0);
    endtask

    task automatic accept(input logic [DW-1:0] d, input bit byp,
                          input bit use_tab, input logic [DW-1:0] tab,
                          output int lowcnt, output logic pend_seen);
        int  w;
        sb_t e;
        @(negedge clk);
        in_valid  = 1'b1;
        in_data   = d;
        bypass    = byp;
        lowcnt    = 0;
        pend_seen = 1'b0;
        w         = 0;
        while (!in_ready && w < 20) begin
            lowcnt++;
            w++;
            @(negedge clk);
        end
        if (!in_ready) begin
            chk("accept_timeout", in_ready, 1);
            in_valid = 1'b0;
            return;
        end
        pend_seen = swap_pending;
        @(posedge clk);
        #1;
        if (m_pend) begin
            m_act  = m_shadow;
            m_pend = 1'b0;
        end
        for (int k = NT - 1; k > 0; k--) md[k] = md[k-1];
        md[0] = d;
        e.data = use_tab ? tab : model(byp);
        e.cyc  = cyc + U + 1;
        sb.push_back(e);
    endtask

    task automatic idle_in();
        @(negedge clk);
        in_valid = 1'b0;
        bypass   = 1'b0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (sb.size() != 0 && w < 60) begin
            @(negedge clk);
            w++;
        end
        chk("drain_outstanding", sb.size(), 0);
    endtask

    task automatic run_impulse(input string ph,
                               input logic [DW-1:0] imp,
                               input logic [DW-1:0] t0,
                               input logic [DW-1:0] t1,
                               input logic [DW-1:0] t2,
                               input logic [DW-1:0] t3,
                               input bit byp);
        logic [DW-1:0] tab[NT];
        int   lc;
        logic ps;
        tab = '{t0, t1, t2, t3, t2, t1, t0};
        for (int i = 0; i < NT; i++) begin
            accept((i == 0) ? imp : 18'h0, byp, 1'b1, tab[i], lc, ps);
            if (i > 0) chk({ph, "_ready_low"}, lc, U + 1);
        end
        idle_in();
        drain();
    endtask

    always @(negedge clk) begin
        if (out_valid) begin
            if (sb.size() == 0) begin
                chk("spurious_out_valid", out_valid, 0);
            end else begin
                mon_e = sb.pop_front();
                chk("out_data", out_data, mon_e.data);
                chk("out_latency", cyc, mon_e.cyc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int   lc;
        logic ps;
        logic [DW-1:0] d;

        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        bypass    = 1'b0;
        coef_we   = 1'b0;
        coef_addr = '0;
        coef_data = '0;
        coef_swap = 1'b0;
        sat_clr   = 1'b0;
        reset_model();
        repeat (2) @(negedge clk);
        check_reset_vals("por");
        reset_n = 1'b1;

        // Default pass-through bank.
        run_impulse("imp_default", 18'h10000,
                    18'h0, 18'h0, 18'h0, 18'h10000, 1'b0);

        // Loaded bank.
        write_coefs(18'h04000, 18'h3C000, 18'h08000, 18'h10000);
        pulse_swap_idle();
        run_impulse("imp_loaded", 18'h10000,
                    18'h02000, 18'h3E000, 18'h04000, 18'h08000, 1'b0);

        // Bypass path.
        run_impulse("bypass", 18'h1ABCD,
                    18'h0, 18'h0, 18'h0, 18'h1ABCD, 1'b1);
        chk("bypass_sat_flag", sat_flag, 0);

        // Sustained valid with a ramp, swap requested during ACC.
        write_coefs(18'h03000, 18'h3D000, 18'h0A000, 18'h12000);
        for (int i = 0; i < 10; i++) begin
            d = 18'(i * 18'h05A3B) ^ 18'h15555;
            accept(d, 1'b0, 1'b0, 18'h0, lc, ps);
            if (i > 0 && i != 3) chk("ramp_ready_low", lc, U + 1);
            if (i == 3) begin
                chk("swap_pending_at_accept", ps, 1);
                chk("swap_cleared_on_accept", swap_pending, 0);
            end
            if (i == 2) begin
                @(negedge clk);
                coef_swap = 1'b1;
                m_pend    = 1'b1;
                @(posedge clk);
                #1;
                coef_swap = 1'b0;
                chk("swap_pending_in_acc", swap_pending, 1);
                repeat (2) @(negedge clk);
                chk("swap_pending_hold", swap_pending, 1);
            end
        end
        idle_in();
        drain();

        // Saturation at both rails.
        write_coefs(18'h1FFFF, 18'h1FFFF, 18'h1FFFF, 18'h1FFFF);
        pulse_swap_idle();
        for (int i = 0; i < 15; i++) begin
            d = (i < 7) ? 18'h1FFFF : 18'h20001;
            accept(d, 1'b0, (i == 6 || i == 14),
                   (i < 7) ? 18'h1FFFF : 18'h20001, lc, ps);
        end
        idle_in();
        drain();
        chk("sat_flag_set", sat_flag, 1);
        @(negedge clk);
        sat_clr = 1'b1;
        @(negedge clk);
        sat_clr = 1'b0;
        chk("sat_flag_cleared", sat_flag, 0);

        // sat_clr held across a saturating OUT edge: set wins.
        accept(18'h20001, 1'b0, 1'b0, 18'h0, lc, ps);
        in_valid = 1'b0;
        sat_clr  = 1'b1;
        repeat (U + 1) @(posedge clk);
        #1;
        sat_clr = 1'b0;
        chk("sat_set_wins", sat_flag, 1);
        drain();

        // Reset at ACC k=2 aborts the sample.
        accept(18'h10000, 1'b0, 1'b0, 18'h0, lc, ps);
        in_valid = 1'b0;
        @(negedge clk);
        coef_swap = 1'b1;
        @(negedge clk);
        coef_swap = 1'b0;
        @(negedge clk);
        chk("pre_reset_sat", sat_flag, 1);
        chk("pre_reset_pending", swap_pending, 1);
        reset_n = 1'b0;
        sb.delete();
        @(negedge clk);
        reset_n = 1'b1;
        check_reset_vals("mid_acc_reset");
        reset_model();
        repeat (10) @(negedge clk);
        run_impulse("imp_after_reset", 18'h10000,
                    18'h0, 18'h0, 18'h0, 18'h10000, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
